// File: rtl/rv32i_lsu.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_lsu
// Purpose  : Load/store unit between the rv32i execute stage and a BUS_W-wide
//            data-memory bus. Steers store bytes onto bus lanes, generates
//            byte enables, sign/zero-extends loads and optionally splits
//            accesses that straddle a bus word into two beats. One request
//            outstanding at a time; completion is a one-cycle pulse.
// Ports    : clk, reset_n (async, active-low)
//            req_valid/req_ready handshake; req_op (0 load, 1 store),
//            req_funct3, req_addr, req_wdata
//            resp_valid pulse with resp_rdata / resp_err
//            mem_req held until mem_ack; mem_we, mem_addr (word aligned),
//            mem_be, mem_wdata; mem_ack with same-cycle mem_rdata
// Revision : 1.0  initial release
// ============================================================================
module rv32i_lsu #(
   parameter int BUS_W          = 32,
   parameter int ADDR_W         = 32,
   parameter int MISALIGN_SPLIT = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_op,
   input  logic [2:0]           req_funct3,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [31:0]          req_wdata,
   output logic                 resp_valid,
   output logic [31:0]          resp_rdata,
   output logic                 resp_err,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [BUS_W/8-1:0]   mem_be,
   output logic [BUS_W-1:0]     mem_wdata,
   input  logic                 mem_ack,
   input  logic [BUS_W-1:0]     mem_rdata
);

   localparam int BUS_B = BUS_W / 8;
   localparam int OFF_W = $clog2(BUS_B);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BEAT0 = 2'd1,
      S_BEAT1 = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic                  r_op;
   logic [2:0]            r_funct3;
   logic [OFF_W-1:0]      r_off;
   logic                  r_split;
   logic                  r_err;
   logic [BUS_B-1:0]      r_be_hi;
   logic [BUS_W-1:0]      r_wd_hi;
   logic [BUS_W-1:0]      r_rdata_lo;
   logic [31:0]           r_rdata;
   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [ADDR_W-1:0]     r_mem_addr;
   logic [BUS_B-1:0]      r_mem_be;
   logic [BUS_W-1:0]      r_mem_wdata;

   // ---------------- request decode (valid only in IDLE) ----------------
   logic [OFF_W-1:0]      w_off;
   logic [2:0]            w_size;
   logic [1:0]            w_align_mask;
   logic [3:0]            w_byte_mask;
   logic                  w_illegal;
   logic                  w_misal;
   logic                  w_err;
   logic [OFF_W:0]        w_end;
   logic                  w_split;
   logic [2*BUS_B-1:0]    w_be_win;
   logic [31:0]           w_wd_masked;
   logic [2*BUS_W-1:0]    w_wd_win;
   logic [ADDR_W-1:0]     w_word0;

   assign w_off = req_addr[OFF_W-1:0];

   always_comb begin
      w_size       = 3'd4;
      w_align_mask = 2'b11;
      w_byte_mask  = 4'b1111;
      case (req_funct3[1:0])
         2'b00: begin w_size = 3'd1; w_align_mask = 2'b00; w_byte_mask = 4'b0001; end
         2'b01: begin w_size = 3'd2; w_align_mask = 2'b01; w_byte_mask = 4'b0011; end
         default: ;
      endcase
   end

   assign w_illegal = req_op ? (req_funct3[2] | (req_funct3 == 3'b011))
                             : ((req_funct3 == 3'b011) | (req_funct3 == 3'b110) |
                                (req_funct3 == 3'b111));
   assign w_misal   = (req_addr[1:0] & w_align_mask) != 2'b00;
   assign w_err     = w_illegal | (w_misal & (MISALIGN_SPLIT == 0));

   // End offset past the last byte; beyond BUS_B means the access spills
   // into the next bus word.
   assign w_end     = {1'b0, w_off} + (OFF_W+1)'(w_size);
   assign w_split   = w_end > (OFF_W+1)'(BUS_B);

   // Two-word windows: low half feeds beat 0, high half feeds beat 1.
   assign w_be_win    = {{(2*BUS_B-4){1'b0}}, w_byte_mask} << w_off;
   assign w_wd_masked = req_wdata & {{8{w_byte_mask[3]}}, {8{w_byte_mask[2]}},
                                     {8{w_byte_mask[1]}}, {8{w_byte_mask[0]}}};
   assign w_wd_win    = req_op ? ({{(2*BUS_W-32){1'b0}}, w_wd_masked} << {w_off, 3'b000})
                               : '0;
   assign w_word0     = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   // ---------------- load assembly and extension ----------------
   logic [BUS_W-1:0]      w_lo;
   logic [BUS_W-1:0]      w_hi;
   logic [31:0]           w_ld_raw;
   logic [31:0]           w_ld_res;

   assign w_lo     = (r_state == S_BEAT1) ? r_rdata_lo : mem_rdata;
   assign w_hi     = (r_state == S_BEAT1) ? mem_rdata  : '0;
   assign w_ld_raw = 32'({w_hi, w_lo} >> {r_off, 3'b000});

   always_comb begin
      w_ld_res = w_ld_raw;
      case (r_funct3)
         3'b000:  w_ld_res = {{24{w_ld_raw[7]}},  w_ld_raw[7:0]};
         3'b001:  w_ld_res = {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
         3'b100:  w_ld_res = {24'h0, w_ld_raw[7:0]};
         3'b101:  w_ld_res = {16'h0, w_ld_raw[15:0]};
         default: ;
      endcase
      if (r_op) w_ld_res = '0;
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (req_valid) w_state_nxt = w_err ? S_RESP : S_BEAT0;
         S_BEAT0: if (mem_ack)   w_state_nxt = r_split ? S_BEAT1 : S_RESP;
         S_BEAT1: if (mem_ack)   w_state_nxt = S_RESP;
         S_RESP:                 w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- datapath / registered bus outputs ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_op        <= 1'b0;
         r_funct3    <= '0;
         r_off       <= '0;
         r_split     <= 1'b0;
         r_err       <= 1'b0;
         r_be_hi     <= '0;
         r_wd_hi     <= '0;
         r_rdata_lo  <= '0;
         r_rdata     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (req_valid) begin
               r_op     <= req_op;
               r_funct3 <= req_funct3;
               r_off    <= w_off;
               r_split  <= w_split;
               r_err    <= w_err;
               r_be_hi  <= w_be_win[2*BUS_B-1:BUS_B];
               r_wd_hi  <= w_wd_win[2*BUS_W-1:BUS_W];
               r_rdata  <= '0;
               if (!w_err) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= req_op;
                  r_mem_addr  <= w_word0;
                  r_mem_be    <= w_be_win[BUS_B-1:0];
                  r_mem_wdata <= w_wd_win[BUS_W-1:0];
               end
            end
            S_BEAT0, S_BEAT1: if (mem_ack) begin
               if ((r_state == S_BEAT0) && r_split) begin
                  r_rdata_lo  <= mem_rdata;
                  r_mem_addr  <= r_mem_addr + ADDR_W'(BUS_B);
                  r_mem_be    <= r_be_hi;
                  r_mem_wdata <= r_wd_hi;
               end else begin
                  r_rdata     <= w_ld_res;
                  r_mem_req   <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_be    <= '0;
                  r_mem_wdata <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = resp_valid ? r_rdata : '0;
   assign resp_err   = resp_valid & r_err;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_be     = r_mem_be;
   assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire
